// File: rtl/spi_arb_pkg.sv
// Shared types and widths for the SPI transaction arbiter and its round-robin selector.
package spi_arb_pkg;

  localparam int MODE_W  = 2;
  localparam int PRESC_W = 3;
  localparam int WDOG_W  = 16;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT_EMPTY,
    S_WR_DRIVE,
    S_WR_PULSE,
    S_WAIT_RX,
    S_RD_PULSE,
    S_RD_CAP,
    S_FINISH
  } arb_state_t;

endpackage

// File: rtl/spi_txn_arbiter_rr_arbiter.sv
// Round-robin selector: first active request at or after the pointer, wrapping.
// The pointer moves to owner+1 when i_adv is pulsed at the end of a transaction.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  i_req,
  input  logic             i_adv,
  input  logic [IDX_W-1:0] i_owner,
  output logic [NREQ-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [IDX_W-1:0] r_ptr;

  always_comb begin : sel
    int c;
    c     = 0;
    o_any = 1'b0;
    o_idx = '0;
    o_gnt = '0;
    for (int k = 0; k < NREQ; k++) begin
      c = (int'(r_ptr) + k) % NREQ;
      if (!o_any && i_req[c]) begin
        o_any = 1'b1;
        o_idx = IDX_W'(c);
      end
    end
    if (o_any) o_gnt[o_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= (i_owner == IDX_W'(NREQ - 1)) ? '0 : i_owner + IDX_W'(1);
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Grants one requester at a time to a shared spi_master and sequences its words
// through the wr / charreceived / rd handshake. Optional watchdog: SPI_ARB_TIMEOUT_EN.
module spi_txn_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int WORD_LEN   = 8,
  parameter int LEN_W      = 4,
  parameter int STROBE_LEN = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*LEN_W-1:0]     req_len,
  input  logic [NREQ*MODE_W-1:0]    req_mode,
  input  logic [NREQ*PRESC_W-1:0]   req_presc,
  input  logic [NREQ-1:0]           req_lsbfirst,
  input  logic [NREQ*WORD_LEN-1:0]  tx_data,
  output logic [NREQ-1:0]           tx_take,
  output logic [WORD_LEN-1:0]       rx_data,
  output logic [NREQ-1:0]           rx_valid,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic                      err,
`ifdef SPI_ARB_TIMEOUT_EN
  output logic                      timeout,
`endif
  output logic [WORD_LEN-1:0]       spi_data_o,
  output logic                      spi_data_oe,
  input  logic [WORD_LEN-1:0]       spi_data_i,
  output logic                      spi_wr,
  output logic                      spi_rd,
  output logic                      spi_res_senderr,
  input  logic                      spi_buffempty,
  input  logic                      spi_charreceived,
  input  logic                      spi_senderr,
  output logic [MODE_W-1:0]         spi_mode,
  output logic [PRESC_W-1:0]        spi_prescaller,
  output logic                      spi_lsbfirst
);

  localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SCNT_W = $clog2(STROBE_LEN + 1);

  arb_state_t          r_state, w_next;
  logic [IDX_W-1:0]    r_owner, w_arb_idx;
  logic [NREQ-1:0]     r_gnt, w_arb_gnt, r_take, r_rxv;
  logic                w_arb_any;
  logic [LEN_W-1:0]    r_len, r_cnt;
  logic [MODE_W-1:0]   r_mode;
  logic [PRESC_W-1:0]  r_presc;
  logic                r_lsb, r_err;
  logic [SCNT_W-1:0]   r_scnt, r_rscnt;
  logic [WORD_LEN-1:0] r_wdata, r_rx;
  logic                w_strobe_last, w_senderr_hit, w_adv, w_wdog_exp;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [WDOG_W-1:0]   r_wdog;
  logic                r_timeout;
  assign w_wdog_exp = ((r_state == S_WAIT_EMPTY) || (r_state == S_WAIT_RX)) && (r_wdog == '1);
  assign timeout    = r_timeout;
`else
  assign w_wdog_exp = 1'b0;
`endif

  assign w_strobe_last = (r_scnt == '0);
  assign w_senderr_hit = spi_senderr && (r_state != S_IDLE);
  assign w_adv         = (r_state == S_FINISH);

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .i_req   (req),
    .i_adv   (w_adv),
    .i_owner (r_owner),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_any   (w_arb_any)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Strobes and oe decode straight from state, so a reset drops them on the next cycle.
  always_comb begin
    w_next      = r_state;
    spi_wr      = 1'b0;
    spi_rd      = 1'b0;
    spi_data_oe = 1'b0;
    done        = '0;
    case (r_state)
      S_IDLE:       if (w_arb_any) w_next = S_GRANT;
      S_GRANT:      w_next = S_WAIT_EMPTY;
      S_WAIT_EMPTY: if (spi_buffempty) w_next = S_WR_DRIVE;
      S_WR_DRIVE: begin
        spi_data_oe = 1'b1;
        w_next      = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        spi_data_oe = 1'b1;
        spi_wr      = 1'b1;
        if (w_strobe_last) w_next = S_WAIT_RX;
      end
      S_WAIT_RX:    if (spi_charreceived) w_next = S_RD_PULSE;
      S_RD_PULSE: begin
        spi_rd = 1'b1;
        if (w_strobe_last) w_next = S_RD_CAP;
      end
      S_RD_CAP:     w_next = (r_cnt == r_len) ? S_FINISH : S_WAIT_EMPTY;
      S_FINISH: begin
        done   = r_gnt;
        w_next = S_IDLE;
      end
      default:      w_next = S_IDLE;
    endcase
    if (w_wdog_exp) w_next = S_FINISH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= '0;
      r_gnt   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_mode  <= '0;
      r_presc <= '0;
      r_lsb   <= 1'b0;
      r_err   <= 1'b0;
      r_scnt  <= '0;
      r_rscnt <= '0;
      r_take  <= '0;
      r_rxv   <= '0;
      r_rx    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_wdog    <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
      r_take <= '0;
      r_rxv  <= '0;
      if (w_senderr_hit) begin
        r_err   <= 1'b1;
        r_rscnt <= SCNT_W'(STROBE_LEN);
      end else if (r_rscnt != '0) begin
        r_rscnt <= r_rscnt - SCNT_W'(1);
      end
      if (((r_state == S_WR_DRIVE) && (w_next == S_WR_PULSE)) ||
          ((r_state == S_WAIT_RX) && (w_next == S_RD_PULSE)))
        r_scnt <= SCNT_W'(STROBE_LEN - 1);
      else if (r_scnt != '0)
        r_scnt <= r_scnt - SCNT_W'(1);
      case (r_state)
        S_IDLE: if (w_arb_any) begin
          r_owner <= w_arb_idx;
          r_gnt   <= w_arb_gnt;
        end
        // Config is frozen here for the whole burst; a senderr in this cycle still counts.
        S_GRANT: begin
          r_len   <= req_len[int'(r_owner)*LEN_W +: LEN_W];
          r_mode  <= req_mode[int'(r_owner)*MODE_W +: MODE_W];
          r_presc <= req_presc[int'(r_owner)*PRESC_W +: PRESC_W];
          r_lsb   <= req_lsbfirst[r_owner];
          r_cnt   <= '0;
          r_err   <= spi_senderr;
        end
        S_WR_PULSE: if (w_strobe_last) r_take <= r_gnt;
        S_RD_CAP: begin
          r_rx  <= spi_data_i;
          r_rxv <= r_gnt;
          if (r_cnt != r_len) r_cnt <= r_cnt + LEN_W'(1);
        end
        S_FINISH: r_gnt <= '0;
        default: ;
      endcase
`ifdef SPI_ARB_TIMEOUT_EN
      if (r_state == S_GRANT) r_timeout <= 1'b0;
      if (w_next != r_state)  r_wdog <= '0;
      else if ((r_state == S_WAIT_EMPTY) || (r_state == S_WAIT_RX))
        r_wdog <= r_wdog + WDOG_W'(1);
      if (w_wdog_exp) begin
        r_err     <= 1'b1;
        r_timeout <= 1'b1;
      end
`endif
    end
  end

  // Transmit word is captured on entry to WR_DRIVE and held through the wr strobe.
  always_ff @(posedge clk) begin
    if ((r_state == S_WAIT_EMPTY) && (w_next == S_WR_DRIVE))
      r_wdata <= tx_data[int'(r_owner)*WORD_LEN +: WORD_LEN];
  end

  assign spi_data_o      = spi_data_oe ? r_wdata : '0;
  assign spi_res_senderr = (r_rscnt != '0);
  assign gnt             = r_gnt;
  assign tx_take         = r_take;
  assign rx_valid        = r_rxv;
  assign rx_data         = r_rx;
  assign err             = r_err;
  assign spi_mode        = r_mode;
  assign spi_prescaller  = r_presc;
  assign spi_lsbfirst    = r_lsb;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Bench for spi_txn_arbiter: behavioural spi_master/client model plus round-robin reference.
module tb_spi_txn_arbiter;

  localparam int NREQ = 4;
  localparam int WL   = 8;
  localparam int LW   = 4;
  localparam int SL   = 8;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0]    req;
  logic [NREQ*LW-1:0] req_len;
  logic [NREQ*2-1:0]  req_mode;
  logic [NREQ*3-1:0]  req_presc;
  logic [NREQ-1:0]    req_lsbfirst;
  logic [NREQ*WL-1:0] tx_data;
  logic [NREQ-1:0]    tx_take, rx_valid, gnt, done;
  logic [WL-1:0]      rx_data, spi_data_o, spi_data_i;
  logic err, spi_data_oe, spi_wr, spi_rd, spi_res_senderr;
  logic spi_buffempty, spi_charreceived, spi_senderr;
  logic [1:0] spi_mode;
  logic [2:0] spi_prescaller;
  logic spi_lsbfirst;
`ifdef SPI_ARB_TIMEOUT_EN
  logic timeout;
`endif

  spi_txn_arbiter #(.NREQ(NREQ), .WORD_LEN(WL), .LEN_W(LW), .STROBE_LEN(SL)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_mode(req_mode),
    .req_presc(req_presc), .req_lsbfirst(req_lsbfirst), .tx_data(tx_data),
    .tx_take(tx_take), .rx_data(rx_data), .rx_valid(rx_valid), .gnt(gnt),
    .done(done), .err(err),
`ifdef SPI_ARB_TIMEOUT_EN
    .timeout(timeout),
`endif
    .spi_data_o(spi_data_o), .spi_data_oe(spi_data_oe), .spi_data_i(spi_data_i),
    .spi_wr(spi_wr), .spi_rd(spi_rd), .spi_res_senderr(spi_res_senderr),
    .spi_buffempty(spi_buffempty), .spi_charreceived(spi_charreceived),
    .spi_senderr(spi_senderr), .spi_mode(spi_mode), .spi_prescaller(spi_prescaller),
    .spi_lsbfirst(spi_lsbfirst)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] words [NREQ][16];
  int         lens  [NREQ];
  logic [1:0] cm    [NREQ];
  logic [2:0] cp    [NREQ];
  logic       cl    [NREQ];
  int         widx  [NREQ];
  bit         rearm [NREQ];

  int p_model, cur, wr_n, rx_n, served, res_cnt, cr_delay, rearm_pend;
  bit exp_err, cr_pend, wr_prev, rd_prev, inj_senderr, rst_on_wr, rst_chk;
  logic [7:0] slave_word;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    onehot = '0;
    if (i >= 0 && i < NREQ) onehot[i] = 1'b1;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] pend, input int p);
    for (int k = 0; k < NREQ; k++)
      if (pend[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic int clamp15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic drive_bus();
    for (int i = 0; i < NREQ; i++) begin
      req_len[i*LW +: LW]  = LW'(lens[i]);
      req_mode[i*2 +: 2]   = cm[i];
      req_presc[i*3 +: 3]  = cp[i];
      req_lsbfirst[i]      = cl[i];
      tx_data[i*WL +: WL]  = words[i][clamp15(widx[i])];
    end
  endtask

  task automatic rand_cfg(input int i, input int maxlen);
    lens[i] = $urandom_range(0, maxlen);
    cm[i]   = 2'($urandom_range(0, 3));
    cp[i]   = 3'($urandom_range(0, 7));
    cl[i]   = 1'($urandom_range(0, 1));
    for (int w = 0; w < 16; w++) words[i][w] = 8'($urandom_range(0, 255));
    widx[i] = 0;
  endtask

  task automatic model_reset();
    cur = -1; p_model = 0; wr_n = 0; rx_n = 0;
    spi_charreceived = 1'b0; spi_senderr = 1'b0;
    cr_pend = 0; wr_prev = 0; rd_prev = 0; res_cnt = 0;
    for (int i = 0; i < NREQ; i++) widx[i] = 0;
    drive_bus();
  endtask

  task automatic step();
    @(negedge clk);
    if (rst_chk) begin
      chk("rst_wr", spi_wr, 0);
      chk("rst_oe", spi_data_oe, 0);
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;
      rst_chk = 0;
      model_reset();
      return;
    end
    if (spi_rd) begin
      chk("wr_rd_excl", spi_wr, 0);
      chk("oe_in_rd", spi_data_oe, 0);
    end
    if (cur < 0 && gnt != '0) begin
      chk("gnt_pick", gnt, onehot(pick(req, p_model)));
      cur = pick(req, p_model);
      wr_n = 0; rx_n = 0; exp_err = 0;
    end
    if (spi_wr && !wr_prev) begin
      chk("wr_owner", (cur >= 0), 1);
      if (cur >= 0) begin
        chk("wr_data", spi_data_o, words[cur][clamp15(wr_n)]);
        chk("cfg", {spi_mode, spi_prescaller, spi_lsbfirst}, {cm[cur], cp[cur], cl[cur]});
        wr_n++;
      end
      slave_word = spi_data_o;
    end
    if (!spi_wr && wr_prev) begin
      cr_pend = 1;
      cr_delay = $urandom_range(0, 6);
    end
    if (cr_pend) begin
      if (cr_delay == 0) begin spi_charreceived = 1'b1; cr_pend = 0; end
      else cr_delay--;
    end
    if (spi_rd && !rd_prev) begin
      spi_data_i = slave_word ^ 8'hF0;
      spi_charreceived = 1'b0;
    end
    wr_prev = spi_wr;
    rd_prev = spi_rd;
    spi_buffempty = ($urandom_range(0, 3) != 0);
    if (tx_take != '0) begin
      chk("tx_take", tx_take, onehot(cur));
      if (cur >= 0) widx[cur]++;
    end
    if (rx_valid != '0) begin
      chk("rx_valid", rx_valid, onehot(cur));
      if (cur >= 0) begin
        chk("rx_data", rx_data, words[cur][clamp15(rx_n)] ^ 8'hF0);
        rx_n++;
      end
    end
    spi_senderr = 1'b0;
    if (done != '0) begin
      chk("done", done, onehot(cur));
      chk("done_err", err, exp_err);
`ifdef SPI_ARB_TIMEOUT_EN
      chk("done_timeout", timeout, 0);
`endif
      if (cur >= 0) begin
        chk("gnt_at_done", gnt, onehot(cur));
        chk("rx_words", rx_n, lens[cur] + 1);
        chk("wr_words", wr_n, lens[cur] + 1);
        p_model = (cur + 1) % NREQ;
        req[cur] = 1'b0;
        if (rearm[cur]) begin rearm[cur] = 0; rearm_pend = cur; end
      end
      served++;
      cur = -1;
    end else if (rearm_pend >= 0) begin
      rand_cfg(rearm_pend, 3);
      req[rearm_pend] = 1'b1;
      rearm_pend = -1;
    end
    if (inj_senderr && cur >= 0 && rx_n == 1 && lens[cur] >= 2) begin
      spi_senderr = 1'b1;
      inj_senderr = 0;
      exp_err = 1;
    end
    if (spi_res_senderr) res_cnt++;
    else if (res_cnt != 0) begin
      chk("res_senderr_len", res_cnt, SL);
      res_cnt = 0;
    end
    if (rst_on_wr && spi_wr) begin
      rst = 1'b1;
      rst_on_wr = 0;
      rst_chk = 1;
    end
    drive_bus();
  endtask

  task automatic run(input int n);
    int cyc;
    served = 0;
    cyc = 0;
    while (served < n && cyc < 20000) begin
      step();
      cyc++;
    end
    chk("complete", served, n);
    repeat (4) step();
  endtask

  task automatic hard_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    spi_data_i = '0;
    spi_buffempty = 1'b1;
    spi_charreceived = 1'b0;
    spi_senderr = 1'b0;
    slave_word = '0;
    rearm_pend = -1;
    inj_senderr = 0; rst_on_wr = 0; rst_chk = 0; exp_err = 0;
    for (int i = 0; i < NREQ; i++) begin
      rand_cfg(i, 0);
      rearm[i] = 0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_gnt0", gnt, 0);
    chk("rst_done0", done, 0);
    chk("rst_err0", err, 0);
    chk("rst_take0", tx_take, 0);
    chk("rst_rxv0", rx_valid, 0);
    chk("rst_rxd0", rx_data, 0);
    chk("rst_wr0", spi_wr, 0);
    chk("rst_rd0", spi_rd, 0);
    chk("rst_oe0", spi_data_oe, 0);
    chk("rst_do0", spi_data_o, 0);
    chk("rst_res0", spi_res_senderr, 0);
    chk("rst_cfg0", {spi_mode, spi_prescaller, spi_lsbfirst}, 0);

    // single word from requester 0
    lens[0] = 0; cm[0] = 2'd0; cp[0] = 3'd2; cl[0] = 1'b0;
    words[0][0] = 8'h55; widx[0] = 0;
    req[0] = 1'b1;
    drive_bus();
    run(1);

    // three-word burst from requester 2, mode 1
    lens[2] = 2; cm[2] = 2'd1; cp[2] = 3'd0; cl[2] = 1'b1;
    words[2][0] = 8'h55; words[2][1] = 8'hAA; words[2][2] = 8'h0F; widx[2] = 0;
    req[2] = 1'b1;
    drive_bus();
    run(1);

    // 0, 1, 3 together from pointer 0; requester 0 re-requests after its grant
    hard_reset();
    rand_cfg(0, 3); rand_cfg(1, 3); rand_cfg(3, 3);
    rearm[0] = 1;
    req = 4'b1011;
    drive_bus();
    run(4);

    // senderr mid-burst on requester 1, clean requester 2 afterwards
    rand_cfg(1, 0); lens[1] = 3;
    rand_cfg(2, 0);
    inj_senderr = 1;
    req[1] = 1'b1; req[2] = 1'b1;
    drive_bus();
    run(2);

    // synchronous reset during a write strobe, then normal service
    rand_cfg(3, 0); lens[3] = 1;
    rst_on_wr = 1;
    req[3] = 1'b1;
    drive_bus();
    run(1);

    // randomized request mixes
    for (int r = 0; r < 6; r++) begin
      int act;
      int cnt;
      act = $urandom_range(1, 15);
      cnt = 0;
      for (int i = 0; i < NREQ; i++) begin
        if (act[i]) begin
          rand_cfg(i, 4);
          req[i] = 1'b1;
          cnt++;
        end
      end
      drive_bus();
      run(cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
